// File: rtl/plights_pkg.sv
// Shared encodings for the police-light sequencer: FSM states, mode codes
// and a small parameter-clamping helper.
package plights_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RED_ON   = 3'd1,
    ST_RED_GAP  = 3'd2,
    ST_BLUE_ON  = 3'd3,
    ST_BLUE_GAP = 3'd4
  } state_t;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ALT   = 2'b01;
  localparam logic [1:0] MODE_MULTI = 2'b10;
  localparam logic [1:0] MODE_ALL   = 2'b11;

  function automatic int clamp_min1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/plights_pwm.sv
// PWM dimmer for the LED enables: free-running 8-bit counter compared
// against BRIGHTNESS, result registered (one extra clock of latency).
module plights_pwm #(
  parameter int BRIGHTNESS = 128
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic red_raw,
  input  logic blue_raw,
  output logic red_pwm,
  output logic blue_pwm
);

  localparam logic [8:0] DUTY = 9'((BRIGHTNESS > 255) ? 255 :
                                   ((BRIGHTNESS < 0) ? 0 : BRIGHTNESS));

  logic [7:0] pwm_q_r;
  logic       pwm_en_s;

  assign pwm_en_s = ({1'b0, pwm_q_r} < DUTY);

  // Free-running duty counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pwm_q_r <= 8'd0;
    end else begin
      pwm_q_r <= pwm_q_r + 8'd1;
    end
  end

  // Gated, registered LED enables.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      red_pwm  <= 1'b0;
      blue_pwm <= 1'b0;
    end else begin
      red_pwm  <= red_raw & pwm_en_s;
      blue_pwm <= blue_raw & pwm_en_s;
    end
  end

endmodule

// File: rtl/plights_sequencer.sv
// Police-light red/blue flash sequencer stepped by a 1-cycle tick strobe.
// Optional LED dimming via plights_pwm when PLIGHTS_SEQ_PWM_EN is defined.
module plights_sequencer
  import plights_pkg::*;
#(
  parameter int HOLD_TICKS = 4,
  parameter int GAP_TICKS  = 1,
  parameter int FLASHES    = 3,
  parameter int CW         = 8,
  parameter int BRIGHTNESS = 128
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic [1:0] mode_in,
  output logic       red_out,
  output logic       blue_out,
  output logic       cycle_out,
  output logic       busy_out
);

  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(clamp_min1(HOLD_TICKS) - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
  localparam logic [CW-1:0] FLASH_LAST = CW'(clamp_min1(FLASHES) - 1);
  localparam bit            GAP_EN     = (GAP_TICKS > 0);

  state_t        state_r, state_nxt;
  logic [1:0]    mode_r, mode_nxt;
  logic [CW-1:0] tick_cnt_r, tick_nxt;
  logic [CW-1:0] flash_cnt_r, flash_nxt;
  logic          red_r, blue_r;
  logic          red_s, blue_s, cycle_s, busy_s;
  logic          red_side_s, flash_end_s, boundary_s;

  // Next-state, counter and output decode; everything moves only on a tick.
  always_comb begin
    state_nxt   = state_r;
    mode_nxt    = mode_r;
    tick_nxt    = tick_cnt_r;
    flash_nxt   = flash_cnt_r;
    flash_end_s = 1'b0;
    boundary_s  = 1'b0;
    cycle_s     = 1'b0;
    red_side_s  = (state_r == ST_RED_ON) || (state_r == ST_RED_GAP);

    if (tick_in) begin
      case (state_r)
        ST_IDLE: begin
          if (mode_in != MODE_OFF) begin
            state_nxt = ST_RED_ON;
            mode_nxt  = mode_in;
            tick_nxt  = CNT_ZERO;
            flash_nxt = CNT_ZERO;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_RED_ON, ST_BLUE_ON: begin
          if (tick_cnt_r != HOLD_LAST) begin
            tick_nxt = tick_cnt_r + CNT_ONE;
          end else if (mode_r == MODE_ALT) begin
            if (red_side_s) begin
              state_nxt = ST_BLUE_ON;
              tick_nxt  = CNT_ZERO;
            end else begin
              boundary_s = 1'b1;
            end
          end else if (GAP_EN) begin
            state_nxt = red_side_s ? ST_RED_GAP : ST_BLUE_GAP;
            tick_nxt  = CNT_ZERO;
          end else begin
            flash_end_s = 1'b1;
          end
        end
        ST_RED_GAP, ST_BLUE_GAP: begin
          if (tick_cnt_r != GAP_LAST) begin
            tick_nxt = tick_cnt_r + CNT_ONE;
          end else begin
            flash_end_s = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          mode_nxt  = MODE_OFF;
          tick_nxt  = CNT_ZERO;
          flash_nxt = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt = state_r;
    end

    // A completed flash either repeats the colour, hands over to blue, or ends the cycle.
    if (flash_end_s) begin
      tick_nxt = CNT_ZERO;
      if (flash_cnt_r != FLASH_LAST) begin
        flash_nxt = flash_cnt_r + CNT_ONE;
        state_nxt = red_side_s ? ST_RED_ON : ST_BLUE_ON;
      end else if (red_side_s) begin
        flash_nxt = CNT_ZERO;
        state_nxt = ST_BLUE_ON;
      end else begin
        boundary_s = 1'b1;
      end
    end else begin
      flash_nxt = flash_nxt;
    end

    if (boundary_s) begin
      cycle_s   = 1'b1;
      tick_nxt  = CNT_ZERO;
      flash_nxt = CNT_ZERO;
      mode_nxt  = mode_in;
      state_nxt = (mode_in == MODE_OFF) ? ST_IDLE : ST_RED_ON;
    end else begin
      cycle_s = 1'b0;
    end

    red_s  = (state_nxt == ST_RED_ON) ||
             ((mode_nxt == MODE_ALL) && (state_nxt == ST_BLUE_ON));
    blue_s = (state_nxt == ST_BLUE_ON) ||
             ((mode_nxt == MODE_ALL) && (state_nxt == ST_RED_ON));
    busy_s = (state_nxt != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_OFF;
      tick_cnt_r  <= CNT_ZERO;
      flash_cnt_r <= CNT_ZERO;
      red_r       <= 1'b0;
      blue_r      <= 1'b0;
      cycle_out   <= 1'b0;
      busy_out    <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      mode_r      <= mode_nxt;
      tick_cnt_r  <= tick_nxt;
      flash_cnt_r <= flash_nxt;
      red_r       <= red_s;
      blue_r      <= blue_s;
      cycle_out   <= cycle_s;
      busy_out    <= busy_s;
    end
  end

`ifdef PLIGHTS_SEQ_PWM_EN
  plights_pwm #(
    .BRIGHTNESS(BRIGHTNESS)
  ) u_pwm (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .red_raw (red_r),
    .blue_raw(blue_r),
    .red_pwm (red_out),
    .blue_pwm(blue_out)
  );
`else
  assign red_out  = red_r;
  assign blue_out = blue_r;
`endif

endmodule

// File: tb/tb_plights_sequencer.sv
// Self-checking bench for plights_sequencer: phase-list reference model
// compared every cycle, plus hand-computed pattern expectations.
`timescale 1ns/1ps
module tb_plights_sequencer;
  import plights_pkg::*;

  localparam int HOLD = 2;
  localparam int GAP  = 1;
  localparam int FL   = 3;
  localparam int CW   = 8;
  localparam int BR   = 64;
  localparam int HOLD_E = (HOLD < 1) ? 1 : HOLD;
  localparam int FL_E   = (FL < 1) ? 1 : FL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] mode = MODE_ALT;
  logic       red_out, blue_out, cycle_out, busy_out;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Reference model: sequence of (red, blue, length-in-ticks) phases per cycle.
  bit ph_r [16];
  bit ph_b [16];
  int ph_len [16];
  int n_ph = 0;
  bit m_busy = 1'b0;
  int m_idx = 0;
  int m_cnt = 0;
  bit m_cycle = 1'b0;
  bit exp_r = 1'b0;
  bit exp_b = 1'b0;
  bit led_r = 1'b0;
  bit led_b = 1'b0;
  int m_pwm = 0;

  int cnt_r, cnt_b, cnt_c, first_b, cnt_both, cnt_xor, c_at;
  logic [17:0] rp, bp;

  always #5 clk = ~clk;

  plights_sequencer #(
    .HOLD_TICKS(HOLD),
    .GAP_TICKS (GAP),
    .FLASHES   (FL),
    .CW        (CW),
    .BRIGHTNESS(BR)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .tick_in  (tick),
    .mode_in  (mode),
    .red_out  (red_out),
    .blue_out (blue_out),
    .cycle_out(cycle_out),
    .busy_out (busy_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void build(input logic [1:0] md);
    int k;
    bit both;
    k = 0;
    both = (md == MODE_ALL);
    if (md == MODE_ALT) begin
      ph_r[0] = 1'b1; ph_b[0] = 1'b0; ph_len[0] = HOLD_E;
      ph_r[1] = 1'b0; ph_b[1] = 1'b1; ph_len[1] = HOLD_E;
      k = 2;
    end else begin
      for (int c = 0; c < 2; c++) begin
        for (int f = 0; f < FL_E; f++) begin
          ph_r[k] = (c == 0) || both;
          ph_b[k] = (c == 1) || both;
          ph_len[k] = HOLD_E;
          k++;
          if (GAP > 0) begin
            ph_r[k] = 1'b0; ph_b[k] = 1'b0; ph_len[k] = GAP;
            k++;
          end
        end
      end
    end
    n_ph = k;
  endfunction

  function automatic void model_update();
`ifdef PLIGHTS_SEQ_PWM_EN
    if (rst) begin
      led_r = 1'b0; led_b = 1'b0; m_pwm = 0;
    end else begin
      led_r = exp_r && (m_pwm < BR);
      led_b = exp_b && (m_pwm < BR);
      m_pwm = (m_pwm + 1) % 256;
    end
`endif
    m_cycle = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
    end else if (tick) begin
      if (!m_busy) begin
        if (mode != MODE_OFF) begin
          m_busy = 1'b1; build(mode); m_idx = 0; m_cnt = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == ph_len[m_idx]) begin
          m_cnt = 0;
          m_idx++;
          if (m_idx == n_ph) begin
            m_cycle = 1'b1;
            m_idx = 0;
            if (mode == MODE_OFF) m_busy = 1'b0;
            else build(mode);
          end
        end
      end
    end
    exp_r = m_busy && ph_r[m_idx];
    exp_b = m_busy && ph_b[m_idx];
`ifndef PLIGHTS_SEQ_PWM_EN
    led_r = exp_r;
    led_b = exp_b;
`endif
  endfunction

  task automatic step(input logic t);
    tick = t;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_red", {31'd0, red_out}, {31'd0, led_r});
      check("model_blue", {31'd0, blue_out}, {31'd0, led_b});
      check("model_cycle", {31'd0, cycle_out}, {31'd0, m_cycle});
      check("model_busy", {31'd0, busy_out}, {31'd0, m_busy});
    end
  end

  initial begin
    rst = 1'b1; tick = 1'b0; mode = MODE_ALT;
    step(1'b0);
    chk_en = 1'b1;
    step(1'b0);
    step(1'b1);
    check("reset_red", {31'd0, red_out}, 32'd0);
    check("reset_blue", {31'd0, blue_out}, 32'd0);
    check("reset_cycle", {31'd0, cycle_out}, 32'd0);
    check("reset_busy", {31'd0, busy_out}, 32'd0);
    rst = 1'b0;

    // ALT, tick every 4 clk: 8 clk red, 8 clk blue, cycle every 16 clk.
    cnt_r = 0; cnt_b = 0; cnt_c = 0; first_b = -1;
    for (int i = 0; i < 64; i++) begin
      step(i % 4 == 0);
      cnt_r += int'(red_out);
      cnt_b += int'(blue_out);
      cnt_c += int'(cycle_out);
      if (first_b < 0 && blue_out === 1'b1) first_b = i;
    end
    check("t1_cycles", cnt_c, 32'd3);
    check("t1_busy", {31'd0, busy_out}, 32'd1);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t1_red_clks", cnt_r, 32'd32);
    check("t1_blue_clks", cnt_b, 32'd32);
    check("t1_first_blue", first_b, 32'd8);
`endif
    rst = 1'b1; step(1'b0); rst = 1'b0;

    // MULTI, tick every clk: red 110110110 then blue 110110110, cycle on clk 18.
    mode = MODE_MULTI;
    cnt_c = 0; c_at = -1; rp = 18'd0; bp = 18'd0;
    for (int i = 0; i < 36; i++) begin
      step(1'b1);
      if (i < 18) begin
        rp[17 - i] = red_out;
        bp[17 - i] = blue_out;
      end
      if (cycle_out === 1'b1) begin
        cnt_c++;
        if (c_at < 0) c_at = i;
      end
    end
    check("t2_cycles", cnt_c, 32'd1);
    check("t2_cycle_at", c_at, 32'd18);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t2_red_pat", {14'd0, rp}, {14'd0, 18'b110110110_000000000});
    check("t2_blue_pat", {14'd0, bp}, {14'd0, 18'b000000000_110110110});
`endif
    rst = 1'b1; step(1'b0); rst = 1'b0;

    // ALT -> OFF mid RED_ON: blue still completes, then idle at the boundary.
    mode = MODE_ALT;
    step(1'b1);
    mode = MODE_OFF;
    step(1'b1);
    step(1'b1);
    step(1'b1);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t3_blue_done", {31'd0, blue_out}, 32'd1);
`endif
    step(1'b1);
    check("t3_cycle", {31'd0, cycle_out}, 32'd1);
    check("t3_busy", {31'd0, busy_out}, 32'd0);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t3_red", {31'd0, red_out}, 32'd0);
    check("t3_blue", {31'd0, blue_out}, 32'd0);
`endif
    step(1'b1);
    check("t3_stay_idle", {31'd0, busy_out}, 32'd0);

    // ALL: both LEDs together in every ON phase, never one alone.
    mode = MODE_ALL;
    cnt_both = 0; cnt_xor = 0;
    for (int i = 0; i < 36; i++) begin
      step(1'b1);
      cnt_xor += int'(red_out ^ blue_out);
      cnt_both += int'(red_out & blue_out);
    end
    check("t4_xor", cnt_xor, 32'd0);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t4_both", cnt_both, 32'd24);
`endif
    mode = MODE_OFF;
    step(1'b1);
    check("t4_stop_cycle", {31'd0, cycle_out}, 32'd1);
    check("t4_stop_busy", {31'd0, busy_out}, 32'd0);

    // Reset in BLUE_GAP together with a tick.
    mode = MODE_MULTI;
    for (int i = 0; i < 12; i++) step(1'b1);
    check("t5_in_gap_busy", {31'd0, busy_out}, 32'd1);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t5_in_gap_dark", {30'd0, red_out, blue_out}, 32'd0);
`endif
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    check("t5_rst_busy", {31'd0, busy_out}, 32'd0);
    check("t5_rst_leds", {30'd0, red_out, blue_out}, 32'd0);
    check("t5_rst_cycle", {31'd0, cycle_out}, 32'd0);
    mode = MODE_OFF;
    step(1'b1);
    check("t5_off_tick", {31'd0, busy_out}, 32'd0);
    mode = MODE_ALT;
    step(1'b0);
    step(1'b0);
    check("t5_no_tick", {31'd0, busy_out}, 32'd0);
    step(1'b1);
    check("t5_restart_busy", {31'd0, busy_out}, 32'd1);
`ifndef PLIGHTS_SEQ_PWM_EN
    check("t5_restart_red", {31'd0, red_out}, 32'd1);
`endif
    step(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
